pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program-counter unit for the Divvy core: the successor to the single-width PC with HALT/Branch/Zero. It holds the fetch address and selects the next one from sequential increment, conditional branch (be/bne, absolute or PC-relative) and call/return. Calls and returns use an internal return-address stack. It sits between the control unit/ALU flags and instruction memory.

## Interface
- PC_W, 16, PC and target width in bits
- RAS_DEPTH, 4, return-address stack entries (≥2, power of two)
- RESET_PC, 0, PC value loaded on reset
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- HALT  in  1  level; freezes all state while high
- Branch  in  1  conditional-branch instruction this cycle
- BrNZ  in  1  0 = branch if Zero (be), 1 = branch if !Zero (bne)
- BrRel  in  1  0 = Target is absolute, 1 = Target is signed two's-complement offset from PC
- Zero  in  1  ALU zero flag
- Call  in  1  push PC+1, jump to Target (always absolute)
- Ret  in  1  pop return address into PC
- Target  in  PC_W  absolute address or offset
- PC  out  PC_W  current fetch address
- Taken  out  1  registered; 1 in the cycle after any redirect
- RasEmpty  out  1  stack holds 0 entries
- RasFull  out  1  stack holds RAS_DEPTH entries
- Fault  out  1  sticky; stack overflow/underflow or Call+Ret conflict

## Operation
Next-PC priority, evaluated on each rising edge:
- RESET (async): PC=RESET_PC, stack count=0, Taken=0, Fault=0.
- HALT: PC, stack, Taken and Fault hold; all other inputs ignored.
- Call and Ret both high: conflict. PC←PC+1, stack unchanged, Fault←1, Taken←0.
- Ret: if the stack is non-empty, PC←top, pop, Taken←1. If empty (underflow), PC←PC+1, Fault←1, Taken←0.
- Call: push PC+1, PC←Target, Taken←1. If full (overflow), the oldest entry is overwritten (circular), count stays RAS_DEPTH, Fault←1.
- Branch with condition met (Zero for be, !Zero for bne): PC←Target when BrRel=0, or PC←PC+Target when BrRel=1. Taken←1.
- Otherwise: PC←PC+1, Taken←0.
- Branch is ignored when Call or Ret is high.

Arithmetic rules:
- All additions are modulo 2^PC_W; PC+1 at all-ones wraps to 0.
- The relative offset uses the full PC_W bits, sign-interpreted.

Other rules:
- Fault clears only on RESET.
- RasEmpty and RasFull are decoded from the registered count, so they are glitch-free.

## Timing
- Single-cycle latency: inputs sampled at edge N take effect on PC after edge N.
- PC, Taken, Fault and the stack are registers. RasEmpty/RasFull derive from registers only.
- Zero must be stable before the edge. There is no combinational path from any input to any output.
- RESET asserting mid-operation aborts immediately, including a pending push or pop.
- Reset values: PC=RESET_PC, Taken=0, RasEmpty=1, RasFull=0, Fault=0.
- Deasserting HALT resumes from the held PC on the next edge.

## Structure
- Package divvy_pc_pkg holds:
  - enum pc_src_t {SRC_INC, SRC_BR_ABS, SRC_BR_REL, SRC_CALL, SRC_RET, SRC_HOLD}
  - the default PC_W constant
- Sub-module pc_ras: circular return-address stack with push, pop, top, count, empty, full and overflow/underflow strobes; parameters PC_W and RAS_DEPTH.
- pc_stack contains the priority mux (producing pc_src_t), the PC register and the Fault/Taken registers.

## Test plan
All scenarios use PC_W=16 and RAS_DEPTH=4.
- Reset/increment: pulse RESET, then 3 idle cycles -> PC 0,1,2,3; Taken=0; RasEmpty=1.
- HALT: at PC=3 hold HALT for 2 cycles with Branch=1, Zero=1 -> PC stays 3. After release, PC=4.
- Branch modes:
  - PC=4, Branch=1, BrNZ=0, Zero=1, BrRel=0, Target=16'h000F -> PC=F, Taken=1.
  - At PC=F, BrRel=1, Target=16'hFFFE -> PC=D.
  - With BrNZ=1, Zero=1 -> PC=E, Taken=0.
- Call/return: Call at PC=10 with Target=20h, then Ret at PC=22h -> PC=20h, then 11h; RasEmpty is 1 again; Fault=0.
- Overflow/underflow: 5 nested Calls -> RasFull=1 after the 4th, Fault=1 after the 5th. Then 5 Rets -> the first 4 return the newest 4 addresses; the 5th gives PC+1 with Fault still 1.
- Conflict/wrap/async reset:
  - Call and Ret together at PC=FFFFh -> PC=0000h, Fault=1, stack unchanged.
  - RESET asserted mid-cycle -> PC=0 before the next edge.

Source files
------------

// File: rtl/divvy_pc_pkg.sv
// Shared types and defaults for the Divvy program-counter unit.
package divvy_pc_pkg;

  localparam int unsigned PC_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    SRC_INC,
    SRC_BR_ABS,
    SRC_BR_REL,
    SRC_CALL,
    SRC_RET,
    SRC_HOLD
  } pc_src_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [PC_W-1:0] mem_d [RAS_DEPTH];
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign count     = count_q;
  // ptr_q addresses the next free slot; the power-of-two depth makes it wrap for free
  assign top       = mem_q[ptr_q - AW'(1)];
  assign do_push   = push & ~pop;
  assign do_pop    = pop & ~push & ~empty;
  assign overflow  = push & ~pop & full;
  assign underflow = pop & ~push & empty;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + AW'(1);
      if (!full) count_d = count_q + CW'(1);
    end else if (do_pop) begin
      ptr_d   = ptr_q - AW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with conditional branch (abs/rel), call/return via pc_ras, and sticky fault.
module pc_stack
  import divvy_pc_pkg::*;
#(
  parameter int unsigned    PC_W      = PC_W_DEFAULT,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HALT,
  input  logic            Branch,
  input  logic            BrNZ,
  input  logic            BrRel,
  input  logic            Zero,
  input  logic            Call,
  input  logic            Ret,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            Taken,
  output logic            RasEmpty,
  output logic            RasFull,
  output logic            Fault
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            taken_q, taken_d;
  logic            fault_q, fault_d;
  pc_src_t         src;
  logic            conflict, br_cond;

  logic                       ras_push, ras_pop;
  logic [PC_W-1:0]            ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       ras_empty, ras_full, ras_ovf, ras_unf;

  assign pc_inc   = pc_q + PC_W'(1);
  assign conflict = Call & Ret;
  assign br_cond  = BrNZ ? ~Zero : Zero;
  assign ras_push = Call & ~HALT;
  assign ras_pop  = Ret & ~HALT;

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (RESET),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  // Priority mux: HALT > Call/Ret conflict > Ret > Call > Branch > increment
  always_comb begin
    src = SRC_INC;
    if (HALT)                 src = SRC_HOLD;
    else if (conflict)        src = SRC_INC;
    else if (Ret)             src = ras_empty ? SRC_INC : SRC_RET;
    else if (Call)            src = SRC_CALL;
    else if (Branch && br_cond) src = BrRel ? SRC_BR_REL : SRC_BR_ABS;
  end

  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    fault_d = fault_q;
    case (src)
      SRC_INC:    pc_d = pc_inc;
      SRC_BR_ABS: pc_d = Target;
      SRC_BR_REL: pc_d = pc_q + Target;
      SRC_CALL:   pc_d = Target;
      SRC_RET:    pc_d = ras_top;
      default:    pc_d = pc_q;
    endcase
    if (src != SRC_HOLD) begin
      taken_d = (src != SRC_INC);
      fault_d = fault_q | conflict | ras_ovf | ras_unf;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      fault_q <= fault_d;
    end
  end

  assign PC       = pc_q;
  assign Taken    = taken_q;
  assign Fault    = fault_q;
  assign RasEmpty = (ras_count == '0);
  assign RasFull  = ras_full;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: a vector table plus hand-written wrap/conflict/async-reset sequences.
module tb_pc_stack;

  logic        CLK = 1'b0;
  logic        RESET, HALT, Branch, BrNZ, BrRel, Zero, Call, Ret;
  logic [15:0] Target;
  logic [15:0] PC;
  logic        Taken, RasEmpty, RasFull, Fault;

  int checks = 0;
  int errors = 0;

  pc_stack #(
    .PC_W      (16),
    .RAS_DEPTH (4),
    .RESET_PC  (16'h0000)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .HALT     (HALT),
    .Branch   (Branch),
    .BrNZ     (BrNZ),
    .BrRel    (BrRel),
    .Zero     (Zero),
    .Call     (Call),
    .Ret      (Ret),
    .Target   (Target),
    .PC       (PC),
    .Taken    (Taken),
    .RasEmpty (RasEmpty),
    .RasFull  (RasFull),
    .Fault    (Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        halt, branch, brnz, brrel, zero, call, ret;
    logic [15:0] target;
    logic [15:0] pc;
    logic        taken, empty, full, fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic h, b, nz, rel, z, c, r,
                              input logic [15:0] t, input logic [15:0] p,
                              input logic tk, e, f, flt);
    vec_t v;
    v.halt = h; v.branch = b; v.brnz = nz; v.brrel = rel; v.zero = z;
    v.call = c; v.ret = r; v.target = t;
    v.pc = p; v.taken = tk; v.empty = e; v.full = f; v.fault = flt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, b, nz, rel, z, c, r, input logic [15:0] t);
    HALT = h; Branch = b; BrNZ = nz; BrRel = rel; Zero = z; Call = c; Ret = r; Target = t;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] p,
                           input logic tk, e, f, flt);
    check({tag, " pc"},    32'(PC),       32'(p));
    check({tag, " taken"}, 32'(Taken),    32'(tk));
    check({tag, " empty"}, 32'(RasEmpty), 32'(e));
    check({tag, " full"},  32'(RasFull),  32'(f));
    check({tag, " fault"}, 32'(Fault),    32'(flt));
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  initial begin
    //                h  b  nz rl z  c  r  target     pc       tk e  f  flt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0003, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 16'h000F, 16'h0003, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 16'h000F, 16'h0003, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0004, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 16'h000F, 16'h000F, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 16'hFFFE, 16'h000D, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 16'h0000, 16'h000E, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 16'h0010, 16'h0010, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0020, 16'h0020, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0021, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0022, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0011, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0012, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0030, 16'h0030, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0040, 16'h0040, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0050, 16'h0050, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0060, 16'h0060, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'h0070, 16'h0070, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0061, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0051, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0041, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0031, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0032, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 16'h0099, 16'h0033, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 16'h0099, 16'h0033, 0, 1, 0, 1));

    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    #2;
    RESET = 1'b1;
    #1;
    check_all("reset", 16'h0000, 0, 1, 0, 0);
    step();
    RESET = 1'b0;
    check_all("reset_hold", 16'h0000, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].halt, vecs[i].branch, vecs[i].brnz, vecs[i].brrel, vecs[i].zero,
            vecs[i].call, vecs[i].ret, vecs[i].target);
      step();
      check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].taken, vecs[i].empty,
                vecs[i].full, vecs[i].fault);
    end

    // Conflict at FFFF: wraps to 0, faults, and the pushed entry survives
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 16'hFFFE);
    step();
    check_all("call_fffe", 16'hFFFE, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step();
    check_all("inc_ffff", 16'hFFFF, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 16'h1234);
    step();
    check_all("conflict", 16'h0000, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 16'h0);
    step();
    check_all("ret_after_conflict", 16'h0001, 1, 1, 0, 1);

    // Plain increment wrap and relative branch wrap
    do_reset();
    drive(0, 1, 0, 0, 1, 0, 0, 16'hFFFF);
    step();
    check_all("br_ffff", 16'hFFFF, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step();
    check_all("wrap_inc", 16'h0000, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 1, 0, 0, 16'hFFFD);
    step();
    check_all("rel_neg_wrap", 16'hFFFD, 1, 1, 0, 0);

    // Async reset mid-cycle with a call pending
    drive(0, 0, 0, 0, 0, 1, 0, 16'h0040);
    step();
    check_all("pre_areset", 16'h0040, 1, 0, 0, 0);
    #2;
    RESET = 1'b1;
    #1;
    check_all("areset_midcycle", 16'h0000, 0, 1, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
    step();
    check_all("post_areset", 16'h0001, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
